// File: rtl/rule110_pkg.sv
// rule110_pkg: shared definitions for the Rule 110 sequencer.
//   - state_t         : controller FSM state encoding
//   - DEF_CELLS       : default automaton width in cells
//   - DEF_WORD_W      : default readout word width
//   - DEF_GEN_W       : default generation-count width
//   - RULE110_TABLE   : next-state lookup, indexed by {left,centre,right}
package rule110_pkg;

  localparam int unsigned DEF_CELLS  = 256;
  localparam int unsigned DEF_WORD_W = 16;
  localparam int unsigned DEF_GEN_W  = 8;

  // Bit n holds the successor of neighbourhood pattern n ({l,c,r}).
  localparam logic [7:0] RULE110_TABLE = 8'b0110_1110;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DUMP,
    DONE
  } state_t;

endpackage

// File: rtl/rule110_seq_ctrl_if.sv
// rule110_seq_ctrl_if: seed-load, run-control and readout signals of the
// Rule 110 sequencer.
//   seed_valid/seed_ready/seed_data : byte-wide seed stream (master -> slave)
//   start/gens                      : run request and generation count
//   busy                            : controller not idle
//   out_valid/out_ready/out_data/out_last : word-wide readout stream
//   done                            : one-cycle end-of-run pulse
// Modports: master (driver of seed/control, sink of readout), slave (the
// sequencer itself).
interface rule110_seq_ctrl_if
  import rule110_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned GEN_W  = DEF_GEN_W
);

  logic              seed_valid;
  logic              seed_ready;
  logic [7:0]        seed_data;
  logic              start;
  logic [GEN_W-1:0]  gens;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              done;

  modport master (
    output seed_valid, seed_data, start, gens, out_ready,
    input  seed_ready, busy, out_valid, out_data, out_last, done
  );

  modport slave (
    input  seed_valid, seed_data, start, gens, out_ready,
    output seed_ready, busy, out_valid, out_data, out_last, done
  );

endinterface

// File: rtl/rule110_next.sv
// rule110_next: purely combinational Rule 110 generation step.
//   cells_i : current generation (cell i's left neighbour is cell i+1)
//   cells_o : next generation
// Build option: define RULE110_WRAP_EN for toroidal boundaries; otherwise
// neighbours beyond either end read as 0.
module rule110_next
  import rule110_pkg::*;
#(
  parameter int unsigned CELLS = DEF_CELLS
) (
  input  logic [CELLS-1:0] cells_i,
  output logic [CELLS-1:0] cells_o
);

  // ext[0] is cell 0's right neighbour, ext[CELLS+1] is cell CELLS-1's left
  // neighbour; ext[i +: 3] is then exactly {left,centre,right} of cell i.
  logic [CELLS+1:0] ext;

`ifdef RULE110_WRAP_EN
  assign ext = {cells_i[0], cells_i, cells_i[CELLS-1]};
`else
  assign ext = {1'b0, cells_i, 1'b0};
`endif

  always_comb begin
    cells_o = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      cells_o[i] = RULE110_TABLE[ext[i +: 3]];
    end
  end

endmodule

// File: rtl/rule110_seq_ctrl.sv
// rule110_seq_ctrl: Rule 110 cellular automaton sequencer.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rule110_seq_ctrl_if.slave -- seed stream in, start/gens control,
//          busy status, readout word stream out, done pulse
// Flow: IDLE accepts seed bytes (shifted in at the LSB end) until start;
// STEP runs one generation per cycle for gens cycles; DUMP streams the cells
// MSB word first; DONE pulses done for one cycle and returns to IDLE with the
// cells retained.
// Build option: RULE110_WRAP_EN (toroidal boundaries, see rule110_next).
module rule110_seq_ctrl
  import rule110_pkg::*;
#(
  parameter int unsigned CELLS  = DEF_CELLS,
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned GEN_W  = DEF_GEN_W
) (
  input  logic                clk,
  input  logic                rst,
  rule110_seq_ctrl_if.slave   bus
);

  localparam int unsigned NWORDS = CELLS / WORD_W;
  localparam int unsigned KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  state_t            state_q;
  logic [CELLS-1:0]  cells_q;
  logic [CELLS-1:0]  cells_d;
  logic [GEN_W-1:0]  gen_q;
  logic [KW-1:0]     k_q;
  logic              busy_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;
  logic [WORD_W-1:0] word_sel;

  rule110_next #(
    .CELLS (CELLS)
  ) u_next (
    .cells_i (cells_q),
    .cells_o (cells_d)
  );

  // Readout word k counts down from the MSB end of the cell register.
  always_comb begin
    word_sel = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (k_q == KW'(i)) begin
        word_sel = cells_q[CELLS-1-i*WORD_W -: WORD_W];
      end
    end
  end

  // start has priority over a seed byte offered in the same cycle.
  assign bus.seed_ready = (state_q == IDLE) && !bus.start;
  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.done       = done_q;
  assign bus.out_data   = out_valid_q ? word_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cells_q     <= '0;
      gen_q       <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            gen_q  <= bus.gens;
            k_q    <= '0;
            busy_q <= 1'b1;
            if (bus.gens == '0) begin
              state_q     <= DUMP;
              out_valid_q <= 1'b1;
              out_last_q  <= (K_LAST == '0);
            end else begin
              state_q <= STEP;
            end
          end else if (bus.seed_valid) begin
            cells_q <= {cells_q[CELLS-9:0], bus.seed_data};
          end
        end

        STEP: begin
          cells_q <= cells_d;
          gen_q   <= gen_q - 1'b1;
          if (gen_q == GEN_W'(1)) begin
            state_q     <= DUMP;
            k_q         <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (K_LAST == '0);
          end
        end

        DUMP: begin
          if (bus.out_ready) begin
            if (k_q == K_LAST) begin
              state_q     <= DONE;
              k_q         <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              k_q        <= k_q + 1'b1;
              out_last_q <= ((k_q + 1'b1) == K_LAST);
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rule110_seq_ctrl.md
RULE110_SEQ_CTRL -- requirements
Module: rule110_seq_ctrl

Interface
REQ-001 SHALL have parameter CELLS, default 256, meaning automaton width in cells (multiple of WORD_W).
REQ-002 SHALL have parameter WORD_W, default 16, meaning readout word width.
REQ-003 SHALL have parameter GEN_W, default 8, meaning width of generation count.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port seed_valid  input  1  seed byte offered.
REQ-007 SHALL have port seed_ready  output  1  seed byte accepted when seed_valid && seed_ready.
REQ-008 SHALL have port seed_data  input  8  seed byte.
REQ-009 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-010 SHALL have port gens  input  GEN_W  generations to compute, latched on accepted start.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port out_valid  output  1  readout word valid.
REQ-013 SHALL have port out_ready  input  1  sink accepts word.
REQ-014 SHALL have port out_data  output  WORD_W  readout word.
REQ-015 SHALL have port out_last  output  1  high with final word of a dump.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the final word transfers.

Function
REQ-017 SHALL hold a CELLS-bit cell register; cell i's left neighbour is cell i+1, right neighbour is cell i-1.
REQ-018 SHALL compute the next generation per Rule 110 on (left,centre,right): 111->0, 110->1, 101->1, 100->0, 011->1, 010->1, 001->1, 000->0.
REQ-019 SHALL use FSM states IDLE, STEP, DUMP, DONE.
REQ-020 IDLE: seed_ready = !start; accepted byte shifts cells left by 8 with seed_data entering bits [7:0]; 32 bytes fully replace a 256-cell seed.
REQ-021 IDLE with start=1: latch gens into gen counter; gens==0 -> DUMP, else -> STEP; start and a seed byte in the same cycle SHALL load no byte.
REQ-022 STEP: one generation per cycle, counter decrements; after the gens-th update -> DUMP (exactly gens cycles in STEP).
REQ-023 DUMP: word index k from 0 to CELLS/WORD_W-1; out_data = cells[CELLS-1-k*WORD_W -: WORD_W] (MSB word first); out_valid=1.
REQ-024 DUMP: k advances only on out_valid && out_ready; out_data, out_last SHALL stay stable while out_ready=0.
REQ-025 out_last SHALL be high exactly when k is the final index; transfer of that word -> DONE.
REQ-026 DONE: done=1 for one cycle, cells retained, -> IDLE; cells may be re-run with a new start without reloading.
REQ-027 start outside IDLE and seed_valid outside IDLE SHALL be ignored (seed_ready=0).
REQ-028 out_valid SHALL be 0 and out_data SHALL be 0 outside DUMP.

Reset
REQ-029 rst SHALL asynchronously force IDLE, cells=0, gen counter=0, k=0, out_valid=0, out_last=0, done=0, busy=0, out_data=0.
REQ-030 rst asserted mid-STEP or mid-DUMP SHALL abort the run with no done pulse; seed_ready=1 on the first edge after release (if start=0).

Configuration
REQ-031 With RULE110_WRAP_EN defined, boundaries SHALL be toroidal: cell CELLS-1's left is cell 0, cell 0's right is cell CELLS-1.
REQ-032 Without RULE110_WRAP_EN, out-of-range neighbours SHALL read as 0.

Structure
REQ-033 Package rule110_pkg SHALL hold the FSM state enum and default CELLS/WORD_W/GEN_W constants.
REQ-034 Next-generation logic SHALL be a combinational sub-module rule110_next (CELLS-bit in/out, wrap honoured via RULE110_WRAP_EN).

Verification
REQ-035 Reset: assert rst mid-DUMP -> out_valid=0, busy=0, done never pulses; after release seed_ready=1, dump of a gens=0 run reads all 0x0000.
REQ-036 Seed 31x 0x00 then 0x01 (cell0=1), gens=1 -> words 0..14 = 0x0000, word 15 = 0x0003 with out_last=1, done pulse next cycle.
REQ-037 Same seed, gens=0 -> no STEP cycles; word 15 = 0x0001, others 0x0000.
REQ-038 Backpressure: out_ready=0 for 5 cycles at k=3 -> out_valid held 1, out_data unchanged, 16 transfers total, done once.
REQ-039 Seed 0x80 then 31x 0x00, gens=1 -> without wrap word 0 = 0x8000, word 15 = 0x0000; with RULE110_WRAP_EN word 0 = 0x8000, word 15 = 0x0001.
REQ-040 start pulsed during STEP and DUMP, seed_valid during DUMP -> no effect; busy stays 1, gen count and output unchanged.
